// File: rtl/alu_display_scanner_pkg.sv
// Shared constants and types for the ALU result display scanner.
// Segment words are ordered {g,f,e,d,c,b,a} and are active-low.

package alu_display_scanner_pkg;

    // All segments off
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Capital 'E' shown on the error digit
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // BCD digit to segment table, entry [n] is the pattern for digit n
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Index of one of the four display digits
    typedef logic [1:0] digit_idx_t;

    // Converter FSM encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // A 5-bit input needs five double-dabble steps, numbered 0..4
    localparam logic [2:0] LAST_STEP = 3'd4;

endpackage

// File: rtl/alu_display_scanner_seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder with a blank input.
// Codes above 9 are shown blank rather than as garbage segments.

module seg7_decoder
    import alu_display_scanner_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Table lookup, forced blank when requested or out of range
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (bcd_i <= 4'd9)) begin
            seg_o = SEG_TABLE[bcd_i];
        end
    end

endmodule

// File: rtl/alu_display_scanner.sv
// Captures a 5-bit ALU result, converts it to two BCD digits with a
// five-step shift-add-3 sequence, and scans the digits onto a 4-digit
// common-anode 7-segment display. The previous value stays visible
// until a conversion completes.
//
// Converter FSM:
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no conversion in flight, display registers stable
//   ST_SHIFT | one double-dabble step per clock; the fifth step publishes

module alu_display_scanner
    import alu_display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] result_in,
    input  logic       err_in,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int               CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    // Prescaler
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    // Scan: digit_idx_q is the next slot to light, slot_q the one lit now
    logic       scan_en_q, scan_en_d;
    digit_idx_t digit_idx_q, digit_idx_d;
    digit_idx_t slot_q, slot_d;

    // Converter working state
    logic [0:0] state_q, state_d;
    logic [4:0] val_q, val_d;
    logic [3:0] ones_w_q, ones_w_d;
    logic [3:0] tens_w_q, tens_w_d;
    logic [2:0] step_q, step_d;
    logic       err_cap_q, err_cap_d;
    logic [3:0] ones_adj;

    // Published display contents
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       err_q, err_d;

    // Registered display outputs
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;

    // Digit mux into the single decoder
    logic [3:0] dig_bcd;
    logic       dig_blank;
    logic       dig_use_e;
    logic [6:0] dec_seg;

    // Prescaler wraps after REFRESH_DIV cycles and pulses tick on the last one
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Advance the scan slot on every tick; nothing is lit before the first one
    always_comb begin
        scan_en_d   = scan_en_q | tick;
        digit_idx_d = digit_idx_q;
        slot_d      = slot_q;
        if (tick) begin
            slot_d      = digit_idx_q;
            digit_idx_d = digit_idx_q + 2'd1;
        end
    end

    // Ones nibble correction applied before each shift; tens never exceeds 3
    assign ones_adj = (ones_w_q >= 4'd5) ? ones_w_q + 4'd3 : ones_w_q;

    // Converter next state: one step per clock, publish on the last step,
    // and a load always (re)starts a fresh capture after any publish
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        ones_w_d  = ones_w_q;
        tens_w_d  = tens_w_q;
        step_d    = step_q;
        err_cap_d = err_cap_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        err_d     = err_q;

        if (state_q == ST_SHIFT) begin
            ones_w_d = {ones_adj[2:0], val_q[4]};
            tens_w_d = {tens_w_q[2:0], ones_adj[3]};
            val_d    = {val_q[3:0], 1'b0};
            step_d   = step_q + 3'd1;
            if (step_q == LAST_STEP) begin
                ones_d  = {ones_adj[2:0], val_q[4]};
                tens_d  = {tens_w_q[2:0], ones_adj[3]};
                err_d   = err_cap_q;
                state_d = ST_IDLE;
            end
        end

        if (load) begin
            val_d     = result_in;
            err_cap_d = err_in;
            ones_w_d  = 4'd0;
            tens_w_d  = 4'd0;
            step_d    = 3'd0;
            state_d   = ST_SHIFT;
        end
    end

    // Select the digit for the slot that will be lit after this edge.
    // Using next-state display contents lets a freshly published result
    // appear on the same edge that publishes it.
    always_comb begin
        dig_bcd   = 4'd0;
        dig_blank = 1'b1;
        dig_use_e = 1'b0;
        case (slot_d)
            2'd0: begin
                dig_bcd   = ones_d;
                dig_blank = 1'b0;
            end
            2'd1: begin
                dig_bcd   = tens_d;
                dig_blank = (tens_d == 4'd0);
            end
            2'd2: begin
                dig_blank = 1'b1;
            end
            default: begin
                dig_blank = 1'b1;
                dig_use_e = err_d;
            end
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .bcd_i   (dig_bcd),
        .blank_i (dig_blank),
        .seg_o   (dec_seg)
    );

    // Anode and segment words are computed together so they switch on one edge
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        if (scan_en_d) begin
            an_d  = ~(4'b0001 << slot_d);
            seg_d = dig_use_e ? SEG_E : dec_seg;
        end
    end

    // Prescaler and scan registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            scan_en_q   <= 1'b0;
            digit_idx_q <= 2'd0;
            slot_q      <= 2'd0;
        end else begin
            cnt_q       <= cnt_d;
            scan_en_q   <= scan_en_d;
            digit_idx_q <= digit_idx_d;
            slot_q      <= slot_d;
        end
    end

    // Converter and published display registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            val_q     <= 5'd0;
            ones_w_q  <= 4'd0;
            tens_w_q  <= 4'd0;
            step_q    <= 3'd0;
            err_cap_q <= 1'b0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            ones_w_q  <= ones_w_d;
            tens_w_q  <= tens_w_d;
            step_q    <= step_d;
            err_cap_q <= err_cap_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            err_q     <= err_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_alu_display_scanner.sv
// Directed test of alu_display_scanner with a short refresh divider.

module tb_alu_display_scanner;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;

    localparam logic [3:0] AN0 = 4'b1110;
    localparam logic [3:0] AN1 = 4'b1101;
    localparam logic [3:0] AN2 = 4'b1011;
    localparam logic [3:0] AN3 = 4'b0111;

    logic       clk;
    logic       reset;
    logic       load;
    logic [4:0] result_in;
    logic       err_in;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks;
    int n_errors;

    alu_display_scanner #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .result_in (result_in),
        .err_in    (err_in),
        .busy      (busy),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Land on the sample just after the edge that starts slot pat
    task automatic wait_slot_start(input logic [3:0] pat);
        int n;
        n = 0;
        while (an == pat && n < 20) begin step(); n++; end
        n = 0;
        while (an != pat && n < 20) begin step(); n++; end
        chk("align_an", an, pat);
    endtask

    task automatic read_digit(input string tag, input logic [3:0] pat, input logic [6:0] exp);
        int n;
        n = 0;
        while (an != pat && n < 20) begin step(); n++; end
        chk({tag, "_an"}, an, pat);
        chk(tag, seg, exp);
    endtask

    // Load so that the conversion ends inside slot 0, then check latency:
    // old digit 0 still shown at E4, new digit 0 at E5, busy high for E0..E4.
    task automatic load_aligned(input string tag, input logic [4:0] v, input logic e,
                                input logic [6:0] old_d0, input logic [6:0] new_d0);
        int bc;
        wait_slot_start(AN3);
        result_in = v; err_in = e; load = 1'b1;
        step();
        load = 1'b0;
        bc = 0;
        if (busy) bc++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy) bc++;
        end
        step();
        if (busy) bc++;
        chk({tag, "_e4_an"}, an, AN0);
        chk({tag, "_e4_seg"}, seg, old_d0);
        step();
        chk({tag, "_e5_seg"}, seg, new_d0);
        chk({tag, "_e5_busy"}, busy, 1'b0);
        chk({tag, "_busy_len"}, bc, 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_an;
        logic [3:0] an_seq [4];
        int bc;
        an_seq[0] = AN0; an_seq[1] = AN1; an_seq[2] = AN2; an_seq[3] = AN3;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; load = 1'b0; result_in = 5'd0; err_in = 1'b0;
        #2;
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, S_BLANK);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dp", dp, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // First tick arrives on the fourth edge after release
        step(); step(); step();
        chk("pre_tick_an", an, 4'b1111);
        chk("pre_tick_seg", seg, S_BLANK);
        step();
        chk("first_tick_an", an, AN0);
        chk("first_tick_seg", seg, S0);

        // 16 slots of 4 cycles each
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 4; c++) begin
                exp_an = an_seq[s % 4];
                chk("scan_an", an, exp_an);
                step();
            end
        end

        load_aligned("ld23", 5'd23, 1'b0, S0, S3);
        read_digit("ld23_d1", AN1, S2);
        read_digit("ld23_d2", AN2, S_BLANK);
        read_digit("ld23_d3", AN3, S_BLANK);
        chk("dp_on", dp, 1'b1);

        load_aligned("ld31", 5'd31, 1'b1, S3, S1);
        read_digit("ld31_d1", AN1, S3);
        read_digit("ld31_d3", AN3, S_E);

        // load 7 then load 20 two cycles later; second load edge is T-3
        wait_slot_start(AN2);
        step(); step();
        result_in = 5'd7; err_in = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        step();
        result_in = 5'd20; load = 1'b1;
        step();
        load = 1'b0;
        chk("re_e0_busy", busy, 1'b1);
        step(); step(); step();
        chk("re_e3_an", an, AN0);
        chk("re_e3_seg", seg, S1);
        chk("re_e3_busy", busy, 1'b1);
        step();
        chk("re_e4_seg", seg, S1);
        step();
        chk("re_e5_seg", seg, S0);
        chk("re_e5_busy", busy, 1'b0);
        read_digit("re_d1", AN1, S2);
        read_digit("re_d3", AN3, S_BLANK);

        load_aligned("ld9", 5'd9, 1'b0, S0, S9);
        read_digit("ld9_d1", AN1, S_BLANK);
        load_aligned("ld10", 5'd10, 1'b0, S9, S0);
        read_digit("ld10_d1", AN1, S1);

        // Load 12, then load 25 on the edge that publishes 12
        wait_slot_start(AN3);
        result_in = 5'd12; load = 1'b1;
        step();
        load = 1'b0;
        step(); step(); step(); step();
        result_in = 5'd25; load = 1'b1;
        step();
        load = 1'b0;
        chk("cc_pub_seg", seg, S2);
        chk("cc_busy", busy, 1'b1);
        bc = 0;
        while (busy && bc < 20) begin step(); bc++; end
        chk("cc_busy_len", bc, 5);
        read_digit("cc_d0", AN0, S5);
        read_digit("cc_d1", AN1, S2);

        // Reset during the third cycle of a conversion
        result_in = 5'd23; load = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_an", an, 4'b1111);
        chk("mid_rst_seg", seg, S_BLANK);
        chk("mid_rst_busy", busy, 1'b0);
        step();
        reset = 1'b0;
        step(); step(); step();
        chk("post_rst_an", an, 4'b1111);
        step();
        chk("post_rst_an0", an, AN0);
        chk("post_rst_seg0", seg, S0);
        chk("post_rst_busy", busy, 1'b0);
        read_digit("post_rst_d1", AN1, S_BLANK);
        read_digit("post_rst_d3", AN3, S_BLANK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
